// File: rtl/diff_commit_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : diff_commit_queue                                               |
// | Brief    : compacts sparse commit lanes into a circular FIFO and drains    |
// |            them onto dense, registered difftest lanes with sequence nums   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module diff_commit_queue #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int DEPTH = 16,
  parameter int PC_W  = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [N_IN-1:0]        in_valid,
  input  logic [N_IN*PC_W-1:0]   in_pc,
  input  logic [N_IN*32-1:0]     in_instr,
  input  logic [N_IN-1:0]        in_wen,
  input  logic [N_IN*8-1:0]      in_wdest,
  input  logic [N_IN*PC_W-1:0]   in_wdata,
  output logic                   in_ready,
  output logic [N_OUT-1:0]       out_valid,
  output logic [N_OUT*8-1:0]     out_index,
  output logic [N_OUT*PC_W-1:0]  out_pc,
  output logic [N_OUT*32-1:0]    out_instr,
  output logic [N_OUT-1:0]       out_wen,
  output logic [N_OUT*8-1:0]     out_wdest,
  output logic [N_OUT*PC_W-1:0]  out_wdata,
  output logic [N_OUT*32-1:0]    out_seq,
  output logic [63:0]            commit_cnt,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow
);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_ready_max = c_cnt_w'(DEPTH - N_IN);
  localparam logic [c_cnt_w-1:0] c_nout      = c_cnt_w'(N_OUT);

  logic [PC_W-1:0] mem_pc_q    [DEPTH];
  logic [31:0]     mem_instr_q [DEPTH];
  logic            mem_wen_q   [DEPTH];
  logic [7:0]      mem_wdest_q [DEPTH];
  logic [PC_W-1:0] mem_wdata_q [DEPTH];

  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic [c_cnt_w-1:0] push_n, pop_n;
  logic               push_en;
  logic [c_ptr_w-1:0] wr_addr [N_IN];
  logic [c_ptr_w-1:0] rd_addr [N_OUT];

  logic [N_OUT-1:0] out_valid_q, out_valid_d;
  logic [PC_W-1:0]  out_pc_q    [N_OUT];
  logic [PC_W-1:0]  out_pc_d    [N_OUT];
  logic [31:0]      out_instr_q [N_OUT];
  logic [31:0]      out_instr_d [N_OUT];
  logic             out_wen_q   [N_OUT];
  logic             out_wen_d   [N_OUT];
  logic [7:0]       out_wdest_q [N_OUT];
  logic [7:0]       out_wdest_d [N_OUT];
  logic [PC_W-1:0]  out_wdata_q [N_OUT];
  logic [PC_W-1:0]  out_wdata_d [N_OUT];
  logic [31:0]      out_seq_q   [N_OUT];
  logic [31:0]      out_seq_d   [N_OUT];
  logic [31:0]      seq_q, seq_d;
  logic [63:0]      commit_cnt_q, commit_cnt_d;
  logic             overflow_q, overflow_d;

  assign in_ready = !flush && (count_q <= c_ready_max);

  always_comb begin
    // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
    push_n = '0;
    for (int k = 0; k < N_IN; k++) begin
      wr_addr[k] = wr_ptr_q + push_n[c_ptr_w-1:0];
      if (in_valid[k]) push_n = push_n + c_cnt_w'(1);
    end
    push_en = in_ready && (|in_valid);
    pop_n   = flush ? '0 : ((count_q > c_nout) ? c_nout : count_q);

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    seq_d        = seq_q + 32'(pop_n);
    commit_cnt_d = commit_cnt_q + 64'(pop_n);
    overflow_d   = overflow_q | ((|in_valid) && !in_ready && !flush);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + push_n[c_ptr_w-1:0];
      rd_ptr_d = rd_ptr_q + pop_n[c_ptr_w-1:0];
      count_d  = count_q + (push_en ? push_n : '0) - pop_n;
    end

    out_valid_d = '0;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_wen_d   = out_wen_q;
    out_wdest_d = out_wdest_q;
    out_wdata_d = out_wdata_q;
    out_seq_d   = out_seq_q;
    for (int k = 0; k < N_OUT; k++) begin
      rd_addr[k] = rd_ptr_q + c_ptr_w'(k);
      if (c_cnt_w'(k) < pop_n) begin
        out_valid_d[k] = 1'b1;
        out_pc_d[k]    = mem_pc_q[rd_addr[k]];
        out_instr_d[k] = mem_instr_q[rd_addr[k]];
        out_wen_d[k]   = mem_wen_q[rd_addr[k]];
        out_wdest_d[k] = mem_wdest_q[rd_addr[k]];
        out_wdata_d[k] = mem_wdata_q[rd_addr[k]];
        out_seq_d[k]   = seq_q + 32'(k);
      end
    end
  end

  // Storage carries no reset; occupancy alone decides which slots are live.
  always_ff @(posedge clock) begin
    if (push_en) begin
      for (int k = 0; k < N_IN; k++) begin
        if (in_valid[k]) begin
          mem_pc_q[wr_addr[k]]    <= in_pc[k*PC_W +: PC_W];
          mem_instr_q[wr_addr[k]] <= in_instr[k*32 +: 32];
          mem_wen_q[wr_addr[k]]   <= in_wen[k];
          mem_wdest_q[wr_addr[k]] <= in_wdest[k*8 +: 8];
          mem_wdata_q[wr_addr[k]] <= in_wdata[k*PC_W +: PC_W];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      seq_q        <= '0;
      commit_cnt_q <= '0;
      overflow_q   <= 1'b0;
      out_valid_q  <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        out_pc_q[k]    <= '0;
        out_instr_q[k] <= '0;
        out_wen_q[k]   <= 1'b0;
        out_wdest_q[k] <= '0;
        out_wdata_q[k] <= '0;
        out_seq_q[k]   <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      seq_q        <= seq_d;
      commit_cnt_q <= commit_cnt_d;
      overflow_q   <= overflow_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      out_wen_q    <= out_wen_d;
      out_wdest_q  <= out_wdest_d;
      out_wdata_q  <= out_wdata_d;
      out_seq_q    <= out_seq_d;
    end
  end

  generate
    for (genvar k = 0; k < N_OUT; k++) begin : g_out
      assign out_index[k*8 +: 8]      = 8'(k);
      assign out_pc[k*PC_W +: PC_W]   = out_pc_q[k];
      assign out_instr[k*32 +: 32]    = out_instr_q[k];
      assign out_wen[k]               = out_wen_q[k];
      assign out_wdest[k*8 +: 8]      = out_wdest_q[k];
      assign out_wdata[k*PC_W +: PC_W] = out_wdata_q[k];
      assign out_seq[k*32 +: 32]      = out_seq_q[k];
    end
  endgenerate

  assign out_valid  = out_valid_q;
  assign commit_cnt = commit_cnt_q;
  assign occupancy  = count_q;
  assign overflow   = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_diff_commit_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_diff_commit_queue                                            |
// | Brief    : directed bench for diff_commit_queue (N_OUT = 4, 2 and 1)       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_diff_commit_queue;
  logic         clk = 1'b0;
  logic         rst, flush;
  logic [3:0]   in_valid, in_wen;
  logic [255:0] in_pc, in_wdata;
  logic [127:0] in_instr;
  logic [31:0]  in_wdest;

  logic         r4, r2, r1, f4, f2, f1;
  logic [3:0]   o4_valid, o4_wen;
  logic [31:0]  o4_index, o4_wdest;
  logic [255:0] o4_pc, o4_wdata;
  logic [127:0] o4_instr, o4_seq;
  logic [1:0]   o2_valid, o2_wen;
  logic [15:0]  o2_index, o2_wdest;
  logic [127:0] o2_pc, o2_wdata;
  logic [63:0]  o2_instr, o2_seq;
  logic [0:0]   o1_valid, o1_wen;
  logic [7:0]   o1_index, o1_wdest;
  logic [63:0]  o1_pc, o1_wdata;
  logic [31:0]  o1_instr, o1_seq;
  logic [63:0]  c4, c2, c1;
  logic [4:0]   q4, q2, q1;

  always #5 clk = ~clk;

  diff_commit_queue #(.N_IN(4), .N_OUT(4), .DEPTH(16), .PC_W(64)) u_dut (
    .clock(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_wen(in_wen), .in_wdest(in_wdest), .in_wdata(in_wdata),
    .in_ready(r4), .out_valid(o4_valid), .out_index(o4_index), .out_pc(o4_pc),
    .out_instr(o4_instr), .out_wen(o4_wen), .out_wdest(o4_wdest), .out_wdata(o4_wdata),
    .out_seq(o4_seq), .commit_cnt(c4), .occupancy(q4), .overflow(f4));

  diff_commit_queue #(.N_IN(4), .N_OUT(2), .DEPTH(16), .PC_W(64)) u_dut_n2 (
    .clock(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_wen(in_wen), .in_wdest(in_wdest), .in_wdata(in_wdata),
    .in_ready(r2), .out_valid(o2_valid), .out_index(o2_index), .out_pc(o2_pc),
    .out_instr(o2_instr), .out_wen(o2_wen), .out_wdest(o2_wdest), .out_wdata(o2_wdata),
    .out_seq(o2_seq), .commit_cnt(c2), .occupancy(q2), .overflow(f2));

  diff_commit_queue #(.N_IN(4), .N_OUT(1), .DEPTH(16), .PC_W(64)) u_dut_n1 (
    .clock(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_wen(in_wen), .in_wdest(in_wdest), .in_wdata(in_wdata),
    .in_ready(r1), .out_valid(o1_valid), .out_index(o1_index), .out_pc(o1_pc),
    .out_instr(o1_instr), .out_wen(o1_wen), .out_wdest(o1_wdest), .out_wdata(o1_wdata),
    .out_seq(o1_seq), .commit_cnt(c1), .occupancy(q1), .overflow(f1));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instance selected for scoreboard checking: 0 -> N_OUT=4, 1 -> N_OUT=1, 2 -> N_OUT=2
  int          sel = 0;
  logic [3:0]  obs_valid;
  logic [63:0] obs_pc [4];
  logic [31:0] obs_seq [4];
  logic        obs_rdy, obs_ovf;
  logic [63:0] obs_cnt;
  logic [4:0]  obs_occ;

  always_comb begin
    obs_valid = '0;
    obs_rdy   = r4;
    obs_ovf   = f4;
    obs_cnt   = c4;
    obs_occ   = q4;
    for (int k = 0; k < 4; k++) begin
      obs_pc[k]  = '0;
      obs_seq[k] = '0;
    end
    case (sel)
      1: begin
        obs_valid = {3'b000, o1_valid};
        obs_pc[0] = o1_pc; obs_seq[0] = o1_seq;
        obs_rdy = r1; obs_ovf = f1; obs_cnt = c1; obs_occ = q1;
      end
      2: begin
        obs_valid = {2'b00, o2_valid};
        for (int k = 0; k < 2; k++) begin
          obs_pc[k] = o2_pc[k*64 +: 64]; obs_seq[k] = o2_seq[k*32 +: 32];
        end
        obs_rdy = r2; obs_ovf = f2; obs_cnt = c2; obs_occ = q2;
      end
      default: begin
        obs_valid = o4_valid;
        for (int k = 0; k < 4; k++) begin
          obs_pc[k] = o4_pc[k*64 +: 64]; obs_seq[k] = o4_seq[k*32 +: 32];
        end
      end
    endcase
  end

  // Reference queue: pcs of accepted entries in arrival order
  logic [63:0] exp_q [$];
  int          m_cnt = 0;
  logic [31:0] m_seq = '0;
  logic [63:0] m_commit = '0;
  logic        m_ovf = 1'b0;
  int          cyc_ctr = 0;

  task automatic cyc(input logic [3:0] v, input logic fl, input logic rs);
    int          nout;
    int          popn;
    logic        rdy;
    logic [63:0] pcs [4];
    logic [63:0] popped [4];
    nout = (sel == 1) ? 1 : (sel == 2) ? 2 : 4;
    rdy  = !fl && (m_cnt <= 12);
    popn = (fl || rs) ? 0 : ((m_cnt < nout) ? m_cnt : nout);
    for (int k = 0; k < 4; k++) begin
      pcs[k]    = 64'h1000 + 64'(cyc_ctr * 16 + k * 4);
      popped[k] = (k < popn) ? exp_q[k] : 64'h0;
      in_pc[k*64 +: 64]    = pcs[k];
      in_instr[k*32 +: 32] = pcs[k][31:0] ^ 32'hdead_0000;
      in_wen[k]            = k[0];
      in_wdest[k*8 +: 8]   = 8'(k + 1);
      in_wdata[k*64 +: 64] = ~pcs[k];
    end
    in_valid = v;
    flush    = fl;
    rst      = rs;
    #1;
    check("in_ready", obs_rdy, rdy);
    @(posedge clk);
    #1;
    if (rs) begin
      exp_q.delete();
      m_seq = '0; m_commit = '0; m_ovf = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (k < popn) begin
          check("lane_pc", obs_pc[k], popped[k]);
          check("lane_seq", obs_seq[k], m_seq + 32'(k));
        end
      end
      for (int k = 0; k < popn; k++) void'(exp_q.pop_front());
      m_seq    = m_seq + 32'(popn);
      m_commit = m_commit + 64'(popn);
      if (fl) exp_q.delete();
      else if (rdy && (|v)) begin
        for (int k = 0; k < 4; k++) if (v[k]) exp_q.push_back(pcs[k]);
      end else if (|v) m_ovf = 1'b1;
    end
    m_cnt = exp_q.size();
    check("out_valid", obs_valid, 64'((1 << popn) - 1));
    check("occupancy", obs_occ, 64'(m_cnt));
    check("commit_cnt", obs_cnt, m_commit);
    check("overflow", obs_ovf, m_ovf);
    cyc_ctr++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = '0; in_wen = '0;
    in_pc = '0; in_wdata = '0; in_instr = '0; in_wdest = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_valid", o4_valid, 0);
    check("rst_pc", o4_pc[63:0], 0);
    check("rst_seq", o4_seq[127:96], 0);
    check("rst_cnt", c4, 0);
    check("rst_occ", q4, 0);
    check("rst_ovf", f4, 0);
    check("rst_ready", r4, 1);

    // T1 sparse compaction
    cyc(4'b1010, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    check("t1_valid", o4_valid, 4'b0011);
    check("t1_pc0", o4_pc[63:0], 64'h1004);
    check("t1_pc1", o4_pc[127:64], 64'h100c);
    check("t1_seq1", o4_seq[63:32], 1);
    check("t1_instr0", o4_instr[31:0], 32'hdead_1004);
    check("t1_wen0", o4_wen[0], 1);
    check("t1_wdest0", o4_wdest[7:0], 8'd2);
    check("t1_wdata0", o4_wdata[63:0], ~64'h1004);
    check("t1_index3", o4_index[31:24], 8'd3);
    check("t1_cnt", c4, 2);
    cyc(4'b0000, 1'b0, 1'b0);

    // T2 N_OUT=2 drains a full group over two cycles
    cyc(4'b0000, 1'b0, 1'b1);
    sel = 2;
    cyc(4'b1111, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    check("t2_seq1", o2_seq[63:32], 1);
    cyc(4'b0000, 1'b0, 1'b0);
    check("t2_seq2", o2_seq[31:0], 2);
    check("t2_seq3", o2_seq[63:32], 3);
    cyc(4'b0000, 1'b0, 1'b0);

    // T3 N_OUT=1 held full input: ready drops, overflow set, stream intact
    cyc(4'b0000, 1'b0, 1'b1);
    sel = 1;
    repeat (10) cyc(4'b1111, 1'b0, 1'b0);
    check("t3_ovf", f1, 1);
    for (int i = 0; i < 40 && m_cnt > 0; i++) cyc(4'b0000, 1'b0, 1'b0);
    check("t3_drained", q1, 0);

    // T6 reset mid-drain with 8 queued, flush asserted too
    cyc(4'b1111, 1'b0, 1'b0);
    cyc(4'b1111, 1'b0, 1'b0);
    cyc(4'b0011, 1'b0, 1'b0);
    check("t6_queued", q1, 8);
    cyc(4'b1111, 1'b1, 1'b1);
    check("t6_pc", o1_pc, 0);
    check("t6_seq", o1_seq, 0);

    // T4 pointer wrap with sparse groups of three
    sel = 0;
    cyc(4'b0111, 1'b0, 1'b0);
    cyc(4'b1011, 1'b0, 1'b0);
    cyc(4'b1101, 1'b0, 1'b0);
    cyc(4'b1110, 1'b0, 1'b0);
    cyc(4'b0111, 1'b0, 1'b0);
    cyc(4'b1011, 1'b0, 1'b0);
    cyc(4'b1101, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);

    // T5 flush with 6 queued and valid input
    cyc(4'b0000, 1'b0, 1'b1);
    sel = 1;
    cyc(4'b1111, 1'b0, 1'b0);
    cyc(4'b0111, 1'b0, 1'b0);
    check("t5_queued", q1, 6);
    cyc(4'b1111, 1'b1, 1'b0);
    check("t5_occ", q1, 0);
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    check("t5_seq", o1_seq, 1);
    cyc(4'b0000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
